// File: rtl/core_imem_axi_pkg.sv
// Shared constants and types for the AXI-lite instruction memory slave and its word array.
package core_imem_axi_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // A misaligned fetch reports SLVERR even when it is also out of range.
  function automatic rresp_e resp_of(input logic misaligned, input logic out_of_range);
    if (misaligned) return RRESP_SLVERR;
    if (out_of_range) return RRESP_DECERR;
    return RRESP_OKAY;
  endfunction

endpackage

// File: rtl/core_imem_axi_if.sv
// AXI-lite read channel bundle between the fetch stage (master) and the instruction memory (slave).
interface core_imem_axi_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/core_imem_array.sv
// Synchronous-read instruction word RAM; write-first load port when IMEM_LOAD_PORT_EN is defined,
// otherwise read-only.
module core_imem_array
  import core_imem_axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_en_i,
  input  logic             rd_nop_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o
`ifdef IMEM_LOAD_PORT_EN
  ,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i
`endif
);

  // NOTE: the storage array has no reset; only the read register below returns to NOP.
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_word;
  logic [31:0] rd_q;

`ifdef IMEM_LOAD_PORT_EN
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_word = (wr_en_i && (wr_idx_i == rd_idx_i)) ? wr_data_i : mem_q[rd_idx_i];
`else
  assign rd_word = mem_q[rd_idx_i];
`endif

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= INSTR_NOP;
    end else if (rd_en_i) begin
      rd_q <= rd_nop_i ? INSTR_NOP : rd_word;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/core_imem_axi.sv
// AXI-lite read-only instruction memory with programmable wait cycles, feeding the fetch stage.
// Optional boot-load write port enabled by defining IMEM_LOAD_PORT_EN.
module core_imem_axi
  import core_imem_axi_pkg::*;
#(
  parameter int unsigned            AXI_AWIDTH   = 32,
  parameter int unsigned            AXI_DWIDTH   = 32,
  parameter int unsigned            DEPTH_WORDS  = 1024,
  parameter logic [AXI_AWIDTH-1:0]  BASE_ADDR    = '0,
  parameter int unsigned            READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  core_imem_axi_if.slave        axi
`ifdef IMEM_LOAD_PORT_EN
  ,
  input  logic                  LOAD_WE,
  input  logic [AXI_AWIDTH-1:0] LOAD_ADDR,
  input  logic [31:0]           LOAD_DATA
`endif
);

  localparam int unsigned         IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]    LAT        = CNT_W'(READ_LATENCY);
  localparam logic [AXI_AWIDTH:0] SPAN_BYTES = {(AXI_AWIDTH+1)'(DEPTH_WORDS)} << 2;

  if (AXI_DWIDTH != 32 || READ_LATENCY > 15 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)
  begin : g_bad_cfg
    $error("core_imem_axi: unsupported parameter set");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic                    latch;
  logic                    addr_chg;

  logic                    arready_q, rvalid_q;
  rresp_e                  rresp_q, rresp_d;
  logic [31:0]             rdata;

  logic                    rd_en, rd_nop, rd_misal, rd_oor;
  logic [AXI_AWIDTH-1:0]   rd_addr;
  logic [AXI_AWIDTH:0]     rd_off;
  logic [IDX_W-1:0]        rd_idx;

  assign addr_chg = axi.ARVALID && (axi.ARADDR != addr_q);

  always_ff @(posedge CLK) begin : state_reg
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RRESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arready_q <= (state_d == ST_RESP);
      rvalid_q  <= (state_d == ST_RESP);
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge CLK) begin : addr_reg
    addr_q <= addr_d;
  end

  // A restart (new PC while busy) takes priority over completing the current beat.
  always_comb begin : next_state
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (axi.ARVALID) latch = 1'b1;
      end
      ST_WAIT: begin
        if (!axi.ARVALID)       state_d = ST_IDLE;
        else if (addr_chg)      latch   = 1'b1;
        else if (cnt_q == 4'd1) state_d = ST_RESP;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (!axi.ARVALID)       state_d = ST_IDLE;
        else if (addr_chg)      latch   = 1'b1;
        else if (axi.RREADY)    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (latch) begin
      addr_d  = axi.ARADDR;
      cnt_d   = LAT;
      state_d = (READ_LATENCY == 0) ? ST_RESP : ST_WAIT;
    end
  end

  // The array is read on the edge that enters RESP, from the live address when it is latched then.
  always_comb begin : output_logic
    rd_addr  = latch ? axi.ARADDR : addr_q;
    rd_off   = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    rd_misal = (rd_addr[1:0] != 2'b00);
    rd_oor   = (rd_off >= SPAN_BYTES);
    rd_idx   = rd_off[IDX_W+1:2];
    rd_nop   = rd_misal || rd_oor;
    rd_en    = (state_d == ST_RESP) && ((state_q != ST_RESP) || latch);
    rresp_d  = rd_en ? resp_of(rd_misal, rd_oor) : rresp_q;
  end

`ifdef IMEM_LOAD_PORT_EN
  logic [AXI_AWIDTH:0] ld_off;
  logic                ld_ok;
  logic [IDX_W-1:0]    ld_idx;

  assign ld_off = {1'b0, LOAD_ADDR} - {1'b0, BASE_ADDR};
  assign ld_ok  = LOAD_WE && !RST && (LOAD_ADDR[1:0] == 2'b00) && (ld_off < SPAN_BYTES);
  assign ld_idx = ld_off[IDX_W+1:2];
`endif

  core_imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i     (CLK),
    .rst_i     (RST),
    .rd_en_i   (rd_en),
    .rd_nop_i  (rd_nop),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rdata)
`ifdef IMEM_LOAD_PORT_EN
    ,
    .wr_en_i   (ld_ok),
    .wr_idx_i  (ld_idx),
    .wr_data_i (LOAD_DATA)
`endif
  );

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RDATA   = rdata;
  assign axi.RRESP   = rresp_q;

endmodule
